// File: rtl/chirp_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chirp_sweep_ctrl
// Description : Chirp sweep controller; emits one FTW per cycle for saw and
//               triangle sweeps from a shadowed fractional accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module chirp_sweep_ctrl #(
    parameter int N     = 32,
    parameter int FRAC  = 32,
    parameter int CNT_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [1:0]          mode,
    input  logic [N+FRAC-1:0]   ftw0_acc,
    input  logic [N+FRAC-1:0]   delta_acc,
    input  logic [CNT_W-1:0]    seg_len,
    output logic [N-1:0]        ftw_out,
    output logic                ftw_valid,
    output logic                busy,
    output logic                dir_down,
    output logic                sweep_start,
    output logic                sweep_done
);

    localparam int c_W = N + FRAC;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_UP   = 2'd1;
    localparam logic [1:0] c_DOWN = 2'd2;

    localparam logic [1:0] c_MODE_SAW_ONCE = 2'd0;
    localparam logic [1:0] c_MODE_SAW_REP  = 2'd1;
    localparam logic [1:0] c_MODE_TRI_REP  = 2'd2;

    logic [1:0]       r_state;
    logic [c_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_busy;
    logic             r_dir;
    logic             r_sstart;
    logic             r_sdone;
    logic [1:0]       r_mode;
    logic [c_W-1:0]   r_ftw0;
    logic [c_W-1:0]   r_delta;
    logic [CNT_W-1:0] r_len_m1;

    logic [1:0]       w_state_nxt;
    logic [c_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_valid_nxt;
    logic             w_dir_nxt;
    logic             w_sstart_nxt;
    logic             w_sdone_nxt;
    logic             w_capture;
    logic [CNT_W-1:0] w_in_len_m1;

    // A zero segment length behaves as a single-sample segment.
    assign w_in_len_m1 = (seg_len == '0) ? '0 : seg_len - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = r_valid;
        w_dir_nxt    = r_dir;
        w_sstart_nxt = 1'b0;
        w_sdone_nxt  = 1'b0;
        w_capture    = 1'b0;
        if (abort) begin
            w_state_nxt = c_IDLE;
            w_valid_nxt = 1'b0;
            w_dir_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        w_capture    = 1'b1;
                        w_state_nxt  = c_UP;
                        w_acc_nxt    = ftw0_acc;
                        w_cnt_nxt    = w_in_len_m1;
                        w_valid_nxt  = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_sstart_nxt = 1'b1;
                    end
                end
                c_UP: begin
                    if (r_cnt != '0) begin
                        w_acc_nxt = r_acc + r_delta;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_mode == c_MODE_SAW_ONCE) begin
                        w_state_nxt = c_IDLE;
                        w_valid_nxt = 1'b0;
                        w_sdone_nxt = 1'b1;
                    end else if (r_mode == c_MODE_SAW_REP) begin
                        w_acc_nxt    = r_ftw0;
                        w_cnt_nxt    = r_len_m1;
                        w_sdone_nxt  = 1'b1;
                        w_sstart_nxt = 1'b1;
                    end else begin
                        // Accumulator holds here so the peak repeats (flat top).
                        w_state_nxt = c_DOWN;
                        w_dir_nxt   = 1'b1;
                        w_cnt_nxt   = r_len_m1;
                    end
                end
                c_DOWN: begin
                    if (r_cnt != '0) begin
                        w_acc_nxt = r_acc - r_delta;
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_mode == c_MODE_TRI_REP) begin
                        w_state_nxt  = c_UP;
                        w_dir_nxt    = 1'b0;
                        w_acc_nxt    = r_ftw0;
                        w_cnt_nxt    = r_len_m1;
                        w_sdone_nxt  = 1'b1;
                        w_sstart_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_valid_nxt = 1'b0;
                        w_dir_nxt   = 1'b0;
                        w_sdone_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_valid_nxt = 1'b0;
                    w_dir_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_dir    <= 1'b0;
            r_sstart <= 1'b0;
            r_sdone  <= 1'b0;
            r_mode   <= '0;
            r_ftw0   <= '0;
            r_delta  <= '0;
            r_len_m1 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= (w_state_nxt != c_IDLE);
            r_dir    <= w_dir_nxt;
            r_sstart <= w_sstart_nxt;
            r_sdone  <= w_sdone_nxt;
            if (w_capture) begin
                r_mode   <= mode;
                r_ftw0   <= ftw0_acc;
                r_delta  <= delta_acc;
                r_len_m1 <= w_in_len_m1;
            end
        end
    end

    assign ftw_out     = r_acc[c_W-1:FRAC];
    assign ftw_valid   = r_valid;
    assign busy        = r_busy;
    assign dir_down    = r_dir;
    assign sweep_start = r_sstart;
    assign sweep_done  = r_sdone;

endmodule
`default_nettype wire
